// File: rtl/lsu.sv
// Load/store unit: turns an ALU effective address and rs2 into one req/ack
// memory transaction, stalling the core until a registered completion pulse.
module lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [1:0]  lane_q, lane_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic        req_q, req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;

    function automatic logic [3:0] lane_enables(input logic [1:0] sz, input logic [1:0] a);
        case (sz)
            2'b00:   return 4'b0001 << a;
            2'b01:   return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] replicate(input logic [1:0] sz, input logic [31:0] w);
        case (sz)
            2'b00:   return {4{w[7:0]}};
            2'b01:   return {2{w[15:0]}};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [1:0] sz, input logic [1:0] a,
                                           input logic u, input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> {a, 3'b000});
        h = a[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   return u ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   return u ? {16'b0, h} : {{16{h[15]}}, h};
            default: return w;
        endcase
    endfunction

    // NOTE: every _d gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        size_d     = size_q;
        uns_d      = uns_q;
        lane_d     = lane_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        rdata_d    = rdata_q;
        req_d      = req_q;
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;

        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    we_d   = we_i;
                    size_d = size_i;
                    uns_d  = uns_i;
                    lane_d = addr_i[1:0];
                    busy_d = 1'b1;
                    if (size_i == 2'b11 || (size_i == 2'b01 && addr_i[0]) ||
                        (size_i == 2'b10 && addr_i[1:0] != 2'b00)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d    = REQ;
                        cnt_d      = '0;
                        req_d      = 1'b1;
                        mem_we_d   = we_i;
                        mem_addr_d = {addr_i[31:2], 2'b00};
                        be_d       = lane_enables(size_i, addr_i[1:0]);
                        wdata_d    = replicate(size_i, wdata_i);
                    end
                end
            end
            REQ: begin
                // An ack in the final wait cycle takes priority over the timeout.
                if (mem_ack_i) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    req_d   = 1'b0;
                    rdata_d = we_q ? 32'h0 : extend(size_q, lane_q, uns_q, mem_rdata_i);
                end else if (cnt_q == LAST_WAIT) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    req_d   = 1'b0;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            lane_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            req_q      <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            lane_q     <= lane_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            req_q      <= req_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign rdata_o     = rdata_q;
    assign mem_req_o   = req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_be_o    = be_q;
    assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu (TIMEOUT=4): each access is walked cycle by cycle
// against hand-computed addresses, lanes, data and completion timing.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic        we_i;
    logic [1:0]  size_i;
    logic        uns_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    int n_checks = 0;
    int n_pass   = 0;

    lsu #(.TIMEOUT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_i     (valid_i),
        .we_i        (we_i),
        .size_i      (size_i),
        .uns_i       (uns_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .rdata_o     (rdata_o),
        .err_o       (err_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_be_o    (mem_be_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " busy"},  32'(busy_o),    32'h0);
        check({tag, " done"},  32'(done_o),    32'h0);
        check({tag, " err"},   32'(err_o),     32'h0);
        check({tag, " req"},   32'(mem_req_o), 32'h0);
    endtask

    // Issues one access and follows it to completion. ack_cyc = 0 means no ack.
    task automatic run_op(input string tag, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] mem_word, input int ack_cyc, input logic bad,
                          input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata, input int done_cyc,
                          input logic exp_err, input logic [31:0] exp_rdata);
        we_i = we; size_i = size; uns_i = uns; addr_i = addr; wdata_i = wdata;
        mem_rdata_i = mem_word;
        valid_i = 1'b1;
        next_cycle();
        valid_i = 1'b1;  // held high: must be ignored while busy
        for (int c = 1; c <= done_cyc; c++) begin
            if (c == 1 && !bad) begin
                check({tag, " mem_addr"},  mem_addr_o,       exp_addr);
                check({tag, " mem_be"},    32'(mem_be_o),    32'(exp_be));
                check({tag, " mem_wdata"}, mem_wdata_o,      exp_wdata);
                check({tag, " mem_we"},    32'(mem_we_o),    32'(we));
            end
            check({tag, " busy"}, 32'(busy_o), 32'h1);
            if (c < done_cyc) begin
                check({tag, " req"},  32'(mem_req_o), 32'(!bad));
                check({tag, " done early"}, 32'(done_o), 32'h0);
            end else begin
                check({tag, " done"},  32'(done_o),    32'h1);
                check({tag, " err"},   32'(err_o),     32'(exp_err));
                check({tag, " rdata"}, rdata_o,        exp_rdata);
                check({tag, " req off"}, 32'(mem_req_o), 32'h0);
                valid_i = 1'b0;
            end
            mem_ack_i = (c == ack_cyc);
            next_cycle();
            mem_ack_i = 1'b0;
        end
        valid_i = 1'b0;
        check_idle_outputs({tag, " after"});
    endtask

    initial begin
        rst = 1'b1; valid_i = 1'b0; we_i = 1'b0; size_i = 2'b00; uns_i = 1'b0;
        addr_i = '0; wdata_i = '0; mem_ack_i = 1'b0; mem_rdata_i = '0;
        #1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        check_idle_outputs("reset");
        check("reset rdata", rdata_o,             32'h0);
        check("reset addr",  mem_addr_o,          32'h0);
        check("reset be",    32'(mem_be_o),       32'h0);
        check("reset wdata", mem_wdata_o,         32'h0);
        check("reset we",    32'(mem_we_o),       32'h0);

        //     tag        we   size  uns addr          wdata         mem word      ack bad exp addr      be       exp wdata    done err exp rdata
        run_op("sw",      1, 2'b10, 0, 32'h100, 32'hDEADBEEF, 32'h0,        1, 0, 32'h100, 4'b1111, 32'hDEADBEEF, 2, 0, 32'h0);
        run_op("lb",      0, 2'b00, 0, 32'h203, 32'h0,        32'h80FF1234, 4, 0, 32'h200, 4'b1000, 32'h0,        5, 0, 32'hFFFFFF80);
        run_op("lbu",     0, 2'b00, 1, 32'h203, 32'h0,        32'h80FF1234, 4, 0, 32'h200, 4'b1000, 32'h0,        5, 0, 32'h00000080);
        run_op("lbu l1",  0, 2'b00, 1, 32'h201, 32'h0,        32'h80FF1234, 2, 0, 32'h200, 4'b0010, 32'h0,        3, 0, 32'h00000012);
        run_op("lb l2",   0, 2'b00, 0, 32'h202, 32'h0,        32'h80FF1234, 1, 0, 32'h200, 4'b0100, 32'h0,        2, 0, 32'hFFFFFFFF);
        run_op("sh",      1, 2'b01, 0, 32'h302, 32'h0000ABCD, 32'h0,        1, 0, 32'h300, 4'b1100, 32'hABCDABCD, 2, 0, 32'h0);
        run_op("sb",      1, 2'b00, 0, 32'h101, 32'h1234565A, 32'h0,        1, 0, 32'h100, 4'b0010, 32'h5A5A5A5A, 2, 0, 32'h0);
        run_op("lh hi",   0, 2'b01, 0, 32'h302, 32'h0,        32'h8001ABCD, 1, 0, 32'h300, 4'b1100, 32'h0,        2, 0, 32'hFFFF8001);
        run_op("lh lo",   0, 2'b01, 0, 32'h300, 32'h0,        32'h8001ABCD, 1, 0, 32'h300, 4'b0011, 32'h0,        2, 0, 32'hFFFFABCD);
        run_op("lhu lo",  0, 2'b01, 1, 32'h300, 32'h0,        32'h8001ABCD, 1, 0, 32'h300, 4'b0011, 32'h0,        2, 0, 32'h0000ABCD);
        run_op("lw mis",  0, 2'b10, 0, 32'h101, 32'h0,        32'h0,        0, 1, 32'h0,   4'b0000, 32'h0,        1, 1, 32'h0);
        run_op("lh mis",  0, 2'b01, 0, 32'h301, 32'h0,        32'h0,        0, 1, 32'h0,   4'b0000, 32'h0,        1, 1, 32'h0);
        run_op("illegal", 1, 2'b11, 0, 32'h400, 32'h0,        32'h0,        0, 1, 32'h0,   4'b0000, 32'h0,        1, 1, 32'h0);
        run_op("timeout", 0, 2'b10, 0, 32'h400, 32'h0,        32'h55AA55AA, 0, 0, 32'h400, 4'b1111, 32'h0,        5, 1, 32'h0);
        run_op("ack@to",  0, 2'b10, 0, 32'h404, 32'h0,        32'h12345678, 4, 0, 32'h404, 4'b1111, 32'h0,        5, 0, 32'h12345678);

        // Reset during an outstanding load: everything clears, no done follows.
        we_i = 1'b0; size_i = 2'b10; uns_i = 1'b0; addr_i = 32'h500; valid_i = 1'b1;
        next_cycle();
        valid_i = 1'b0;
        check("rst-mid req c1", 32'(mem_req_o), 32'h1);
        next_cycle();
        rst = 1'b1;
        mem_ack_i = 1'b1;
        next_cycle();
        rst = 1'b0;
        mem_ack_i = 1'b0;
        check_idle_outputs("rst-mid");
        check("rst-mid addr",  mem_addr_o,    32'h0);
        check("rst-mid be",    32'(mem_be_o), 32'h0);
        check("rst-mid rdata", rdata_o,       32'h0);
        next_cycle();
        check("rst-mid no done", 32'(done_o), 32'h0);
        run_op("post-rst", 0, 2'b10, 0, 32'h600, 32'h0, 32'hCAFEF00D, 2, 0, 32'h600, 4'b1111, 32'h0, 3, 0, 32'hCAFEF00D);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the single-cycle RISC-V core. It sits directly downstream of the ALU and consumes the ALU `result` as the effective address and `rs2` as store data. It runs a req/ack transaction against data memory, generating byte enables and sign/zero-extending load data. While a transaction is in flight it holds the core in a stall; it returns the load data, or an error, with a one-cycle completion pulse.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum number of cycles spent waiting for `mem_ack_i` before the access is aborted; legal range 1..255.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `valid_i`  in  1  memory operation request from execute.
- `we_i`  in  1  1 = store (sb/sh/sw), 0 = load.
- `size_i`  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- `uns_i`  in  1  1 = zero-extend load data (lbu/lhu), 0 = sign-extend.
- `addr_i`  in  32  effective address, taken from the ALU `result`.
- `wdata_i`  in  32  store data (`rs2`).
- `busy_o`  out  1  stall to the core; high whenever the state is not IDLE.
- `done_o`  out  1  one-cycle completion pulse.
- `rdata_o`  out  32  extended load data; valid only while `done_o` is high.
- `err_o`  out  1  high together with `done_o` on a misaligned, illegal or timed-out access.
- `mem_req_o`  out  1  memory request.
- `mem_we_o`  out  1  memory write enable.
- `mem_addr_o`  out  32  word-aligned address, `{addr[31:2],2'b00}`.
- `mem_be_o`  out  4  byte-lane enables.
- `mem_wdata_o`  out  32  lane-replicated store data.
- `mem_ack_i`  in  1  memory completion; read data is valid in the same cycle.
- `mem_rdata_i`  in  32  memory read word.

## Operation
- FSM states: IDLE, REQ, DONE.
- **IDLE:**
  - If `valid_i` is high, capture `we_i`, `size_i`, `uns_i`, `addr_i` and `wdata_i`.
  - A misaligned or illegal request goes to DONE with the error flag set and never asserts `mem_req_o`. Misaligned/illegal means: `size_i==11`, or half with `addr[0]==1`, or word with `addr[1:0]!=0`.
  - Any other request goes to REQ and clears the timeout counter.
- **REQ:**
  - `mem_req_o` is held high. `mem_we_o`, `mem_addr_o`, `mem_be_o` and `mem_wdata_o` are held stable.
  - When `mem_ack_i` is high: latch the extended load data (0 for a store) and go to DONE.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT-1` without an ack: go to DONE with the error flag set and `rdata` = 0.
  - If ack and timeout occur in the same cycle, the ack wins (no error).
- **DONE:**
  - `done_o` = 1, and `err_o` = the error flag, for exactly one cycle.
  - Then go to IDLE.
- `valid_i` is ignored in REQ and DONE. The core must hold the instruction while `busy_o` is high.
- `mem_ack_i` is ignored outside REQ.
- **Byte enables:**
  - Byte: `4'b0001 << addr[1:0]`.
  - Half: `0011` if `addr[1]==0`, else `1100`.
  - Word: `1111`.
- **Store data:** byte is replicated ×4 (`{4{wdata[7:0]}}`); half is replicated ×2; word is passed through.
- **Load data:**
  - Select the lane given by `addr[1:0]` (byte) or `addr[1]` (half).
  - Extend to 32 bits: with bit 7 (byte) or bit 15 (half) when `uns_i==0`, with zeros when `uns_i==1`.
  - A word load passes through unchanged.

## Timing
- **Reset values:** state IDLE; every output 0, including `mem_addr_o`, `mem_be_o`, `mem_wdata_o` and `rdata_o`.
- **Reset mid-transaction:** `mem_req_o` drops at the next edge and no `done_o` is generated. The memory side must tolerate an abandoned request.
- **Latency:** request accepted at edge 0 → `mem_req_o` high from cycle 1. Ack in cycle k → `done_o` in cycle k+1.
  - Minimum latency, with ack in cycle 1: `done_o` in cycle 2.
  - Throughput: at most one operation per 3 cycles.
- **Error path:** a misaligned request gives `done_o`/`err_o` in cycle 1 with no memory traffic.
- **Timeout:** `done_o`/`err_o` in cycle `TIMEOUT+1` after acceptance; `mem_req_o` is low in that cycle.
- **Outputs:** all outputs are registered; no combinational path from `mem_ack_i` to `done_o`.
- **`busy_o`:** rises the cycle after acceptance and falls together with `done_o` (i.e. it is low again in the cycle after DONE).

## Test plan
- Word store, `addr=0x100`, `wdata=0xDEADBEEF`, ack in cycle 1 → `mem_addr_o=0x100`, `mem_be_o=1111`, `mem_wdata_o=0xDEADBEEF`, `mem_we_o=1`; `done_o` in cycle 2, `err_o=0`.
- Byte load (`lb`), `addr=0x203`, `mem_rdata_i=0x80FF1234`, ack after 3 wait cycles → `mem_addr_o=0x200`, `mem_be_o=1000`, `rdata_o=0xFFFFFF80`; the same access with `uns_i=1` → `rdata_o=0x00000080`.
- Half store, `addr=0x302`, `wdata=0x0000ABCD` → `mem_be_o=1100`, `mem_wdata_o=0xABCDABCD`; half load of `0x8001ABCD` at `0x302` with `uns_i=0` → `rdata_o=0xFFFF8001`.
- Misaligned word load at `0x101` → `mem_req_o` never asserted; `done_o=1`, `err_o=1` in cycle 1.
- Timeout with `TIMEOUT=4` and no ack → `mem_req_o` high in cycles 1–4, `done_o=err_o=1` in cycle 5, `rdata_o=0`. Ack coincident with the timeout cycle → `err_o=0`.
- Assert `rst` in cycle 2 of an outstanding load → all outputs 0 at the next edge, no `done_o`; a new request accepted afterwards completes normally.
